// File: rtl/br_enc_bin2onehot_flow_if.sv
// Push/pop bus for the flow-controlled binary-to-onehot encoder.
// Handshake: a beat transfers on any cycle where valid && ready are both
// high; once valid rises it stays high with a stable payload until that
// transfer, and ready may depend on the downstream ready but never on valid.
interface br_enc_bin2onehot_flow_if #(
  parameter int NumValues = 2,
  parameter int NumLanes  = 1
);
  localparam int BinWidth = $clog2(NumValues);

  logic                              push_valid;
  logic                              push_ready;
  logic [NumLanes-1:0]               push_lane_valid;
  logic [NumLanes*BinWidth-1:0]      push_bin;
  logic                              pop_valid;
  logic                              pop_ready;
  logic [NumLanes*NumValues-1:0]     pop_onehot;
  logic [NumValues-1:0]              pop_merged;
  logic [NumLanes-1:0]               pop_oor;

  // Producer/consumer side (drives push payload and pop_ready).
  modport master (
    output push_valid, push_lane_valid, push_bin, pop_ready,
    input  push_ready, pop_valid, pop_onehot, pop_merged, pop_oor
  );

  // Encoder side.
  modport slave (
    input  push_valid, push_lane_valid, push_bin, pop_ready,
    output push_ready, pop_valid, pop_onehot, pop_merged, pop_oor
  );
endinterface

// File: rtl/br_enc_bin2onehot_flow.sv
// Multi-lane binary-to-onehot encoder with one registered ready/valid stage,
// per-lane out-of-range flags, a cross-lane OR-merged vector and a
// saturating count of beats that carried any out-of-range lane.
module br_enc_bin2onehot_flow #(
  parameter int NumValues     = 2,
  parameter int NumLanes      = 1,
  parameter int ErrCountWidth = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  br_enc_bin2onehot_flow_if.slave  bus,
  input  logic                     err_clear,
  output logic [ErrCountWidth-1:0] err_count
);
  localparam int BinWidth = $clog2(NumValues);
  localparam bit IsPow2   = (NumValues == (1 << BinWidth));
  localparam logic [ErrCountWidth-1:0] ErrMax = '1;

  logic [NumLanes-1:0]           in_range;
  logic [NumLanes*NumValues-1:0] onehot_d;
  logic [NumValues-1:0]          merged_d;
  logic [NumLanes-1:0]           oor_d;
  logic                          any_oor;
  logic                          push_ready_c;
  logic                          push_fire;

  logic                          pop_valid_q;
  logic [NumLanes*NumValues-1:0] pop_onehot_q;
  logic [NumValues-1:0]          pop_merged_q;
  logic [NumLanes-1:0]           pop_oor_q;
  logic [ErrCountWidth-1:0]      err_count_q;

  // Range check: with a power-of-2 value count every index is legal, so the
  // comparator is not built at all.
  if (IsPow2) begin : g_pow2
    assign in_range = '1;
  end else begin : g_npow2
    // Per-lane index-below-NumValues compare.
    always_comb begin
      in_range = '0;
      for (int i = 0; i < NumLanes; i++) begin
        in_range[i] = bus.push_bin[i*BinWidth +: BinWidth] < BinWidth'(NumValues);
      end
    end
  end

  // Decode every lane and OR the lanes together ahead of the register.
  always_comb begin
    logic [BinWidth-1:0] lane_bin;
    lane_bin = '0;
    onehot_d = '0;
    merged_d = '0;
    oor_d    = '0;
    for (int i = 0; i < NumLanes; i++) begin
      lane_bin = bus.push_bin[i*BinWidth +: BinWidth];
      if (bus.push_lane_valid[i]) begin
        if (in_range[i]) begin
          for (int v = 0; v < NumValues; v++) begin
            if (lane_bin == BinWidth'(v)) begin
              onehot_d[i*NumValues + v] = 1'b1;
            end
          end
        end else begin
          oor_d[i] = 1'b1;
        end
      end
    end
    for (int i = 0; i < NumLanes; i++) begin
      merged_d = merged_d | onehot_d[i*NumValues +: NumValues];
    end
  end

  assign any_oor      = |oor_d;
  assign push_ready_c = !pop_valid_q || bus.pop_ready;
  assign push_fire    = bus.push_valid && push_ready_c;

  // Pipeline stage: load on accept (also when popping the same cycle),
  // drop valid on a pop with no replacement, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_valid_q  <= 1'b0;
      pop_onehot_q <= '0;
      pop_merged_q <= '0;
      pop_oor_q    <= '0;
    end else if (push_fire) begin
      pop_valid_q  <= 1'b1;
      pop_onehot_q <= onehot_d;
      pop_merged_q <= merged_d;
      pop_oor_q    <= oor_d;
    end else if (bus.pop_ready) begin
      pop_valid_q  <= 1'b0;
    end
  end

  // Saturating error-beat counter; clear wins but still counts a
  // coincident erroring beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count_q <= '0;
    end else if (err_clear) begin
      err_count_q <= (push_fire && any_oor) ? ErrCountWidth'(1) : '0;
    end else if (push_fire && any_oor && (err_count_q != ErrMax)) begin
      err_count_q <= err_count_q + ErrCountWidth'(1);
    end
  end

  assign bus.push_ready = push_ready_c;
  assign bus.pop_valid  = pop_valid_q;
  assign bus.pop_onehot = pop_onehot_q;
  assign bus.pop_merged = pop_merged_q;
  assign bus.pop_oor    = pop_oor_q;
  assign err_count      = err_count_q;

`ifndef SYNTHESIS
  a_params: assert property (@(posedge clk)
    (NumValues >= 2) && (NumLanes >= 1) && (ErrCountWidth >= 1));

  a_push_hold: assert property (@(posedge clk) disable iff (rst)
    bus.push_valid && !push_ready_c |=>
      bus.push_valid && $stable(bus.push_lane_valid) && $stable(bus.push_bin));

  a_no_x: assert property (@(posedge clk) disable iff (rst)
    !$isunknown(bus.push_valid) && !$isunknown(bus.pop_ready));

  a_merged: assert property (@(posedge clk) disable iff (rst)
    pop_merged_q == (pop_merged_q | '0) &&
    ((pop_valid_q == 1'b0) || (pop_merged_q != '0) == (pop_onehot_q != '0)));

  a_pop_stable: assert property (@(posedge clk) disable iff (rst)
    pop_valid_q && !bus.pop_ready |=>
      pop_valid_q && $stable(pop_onehot_q) && $stable(pop_merged_q) &&
      $stable(pop_oor_q));

  a_err_monotonic: assert property (@(posedge clk)
    !rst && !err_clear |=> rst || (err_count_q >= $past(err_count_q)));

  for (genvar gi = 0; gi < NumLanes; gi++) begin : g_lane_chk
    a_lane_onehot0: assert property (@(posedge clk) disable iff (rst)
      $onehot0(pop_onehot_q[gi*NumValues +: NumValues]));
    a_lane_nonzero: assert property (@(posedge clk) disable iff (rst)
      (|onehot_d[gi*NumValues +: NumValues]) ==
        (bus.push_lane_valid[gi] && !oor_d[gi]));
    a_lane_in_merge: assert property (@(posedge clk) disable iff (rst)
      (pop_onehot_q[gi*NumValues +: NumValues] & ~pop_merged_q) == '0);
  end
`endif

endmodule
